// File: rtl/gcd_engine_pkg.sv
// Shared types for the GCD engine: FSM state encoding,
// step-counter saturation value and Stein shift-width helper.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_Y  = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // All-ones pattern; truncated to the counter width it saturates at 2^CNT_W-1.
  localparam int STEP_SAT_ONES = -1;

  function automatic int shw(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/gcd_engine_if.sv
// Operand entry / result bundle of the GCD engine.
// master drives operands, slave (the engine) drives results.
interface gcd_engine_if
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);

  logic             enter;
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic             halt;
  logic             busy;
  state_t           state;
  logic [CNT_W-1:0] steps;

  modport master (
    output enter, in,
    input  out, halt, busy, state, steps
  );

  modport slave (
    input  enter, in,
    output out, halt, busy, state, steps
  );

endinterface

// File: rtl/gcd_step.sv
// One GCD iteration: subtract-only by default, binary (Stein)
// when GCD_STEIN_EN is defined.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SW    = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef GCD_STEIN_EN
  input  logic [SW-1:0]    sh,
  output logic [SW-1:0]    nsh,
`endif
  output logic [WIDTH-1:0] na,
  output logic [WIDTH-1:0] nb,
  output logic [WIDTH-1:0] res,
  output logic             eq
);

  always_comb begin
    na = a;
    nb = b;
    eq = (a == b);
`ifdef GCD_STEIN_EN
    nsh = sh;
    res = a << sh;
    if (!a[0] && !b[0]) begin
      na  = a >> 1;
      nb  = b >> 1;
      nsh = sh + SW'(1);
    end else if (!a[0]) begin
      na = a >> 1;
    end else if (!b[0]) begin
      nb = b >> 1;
    end else if (a > b) begin
      na = a - b;
    end else begin
      nb = b - a;
    end
`else
    res = a;
    if (a > b) begin
      na = a - b;
    end else begin
      nb = b - a;
    end
`endif
  end

endmodule

// File: rtl/gcd_engine.sv
// GCD engine top: serial X/Y entry on an edge-qualified strobe.
// Optional binary datapath via GCD_STEIN_EN (default: subtract loop).
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic         clk,
  input logic         reset,
  gcd_engine_if.slave bus
);

  localparam logic [CNT_W-1:0] STEPS_MAX =
    CNT_W'(STEP_SAT_ONES);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic             enter_q;
  logic             rise;

  logic [WIDTH-1:0] na, nb, res;
  logic             eq;

`ifdef GCD_STEIN_EN
  localparam int SW = shw(WIDTH);
  logic [SW-1:0] sh_q, sh_d, nsh;
`endif

  assign rise = bus.enter & ~enter_q;

  gcd_step #(
`ifdef GCD_STEIN_EN
    .SW    (SW),
`endif
    .WIDTH (WIDTH)
  ) u_step (
    .a   (a_q),
    .b   (b_q),
`ifdef GCD_STEIN_EN
    .sh  (sh_q),
    .nsh (nsh),
`endif
    .na  (na),
    .nb  (nb),
    .res (res),
    .eq  (eq)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    halt_d  = halt_q;
    steps_d = steps_q;
`ifdef GCD_STEIN_EN
    sh_d    = sh_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          a_d     = bus.in;
          steps_d = '0;
          state_d = WAIT_Y;
        end
      end
      WAIT_Y: begin
        if (rise) begin
          b_d = bus.in;
`ifdef GCD_STEIN_EN
          sh_d = '0;
`endif
          // a zero operand short-circuits: gcd(x,0)=x
          if (a_q == '0 || bus.in == '0) begin
            out_d   = a_q | bus.in;
            halt_d  = 1'b1;
            state_d = DONE;
          end else begin
            state_d = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        if (eq) begin
          out_d   = res;
          halt_d  = 1'b1;
          state_d = DONE;
        end else begin
          a_d = na;
          b_d = nb;
`ifdef GCD_STEIN_EN
          sh_d = nsh;
`endif
          if (steps_q != STEPS_MAX)
            steps_d = steps_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (rise) begin
          a_d     = bus.in;
          halt_d  = 1'b0;
          steps_d = '0;
          state_d = WAIT_Y;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      halt_q  <= 1'b0;
      steps_q <= '0;
      enter_q <= 1'b0;
`ifdef GCD_STEIN_EN
      sh_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      halt_q  <= halt_d;
      steps_q <= steps_d;
      enter_q <= bus.enter;
`ifdef GCD_STEIN_EN
      sh_q    <= sh_d;
`endif
    end
  end

  assign bus.out   = out_q;
  assign bus.halt  = halt_q;
  assign bus.busy  = (state_q == COMPUTE);
  assign bus.state = state_q;
  assign bus.steps = steps_q;

endmodule
